// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : psum_accumulator
// Purpose  : Accumulates a stream of signed partial sums per group, then
//            shifts, saturates and presents one result per group.
// Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
  parameter int IN_WIDTH  = 33,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_SCALE = 0,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  // Compare width holds any shifted accumulator value and both clamp limits.
  localparam int C_CMP_W = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;
  localparam logic signed [C_CMP_W-1:0] C_SAT_MAX =
    {{(C_CMP_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [C_CMP_W-1:0] C_SAT_MIN =
    {{(C_CMP_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
  logic                  out_ovf_q, out_ovf_d;

  logic signed [ACC_WIDTH-1:0] w_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic signed [C_CMP_W-1:0]   w_wide;
  logic [OUT_WIDTH-1:0]        w_sat;
  logic [CNT_WIDTH-1:0]        w_cnt_next;
  logic                        w_ovf_next;

  always_comb begin
    w_ext      = {{(ACC_WIDTH-IN_WIDTH+1){in_data[IN_WIDTH-1]}}, in_data[IN_WIDTH-2:0]};
    w_sum      = acc_q + w_ext;
    w_cnt_next = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // Wrap only when both operands agree in sign and the sum disagrees.
    w_ovf_next = ovf_q | ((acc_q[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                          (w_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]));
    w_shifted  = w_sum >>> OUT_SCALE;
    w_wide     = {{(C_CMP_W-ACC_WIDTH){w_shifted[ACC_WIDTH-1]}}, w_shifted};
    if (w_wide > C_SAT_MAX) begin
      w_sat = C_SAT_MAX[OUT_WIDTH-1:0];
    end else if (w_wide < C_SAT_MIN) begin
      w_sat = C_SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      w_sat = w_wide[OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = w_sum;
          cnt_d = w_cnt_next;
          ovf_d = w_ovf_next;
          if (in_last) begin
            state_d     = ST_OUTPUT;
            out_data_d  = w_sat;
            out_count_d = w_cnt_next;
            out_ovf_d   = w_ovf_next;
          end
        end
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_accumulator
// Purpose  : Directed bench; three configurations share one input stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        arst;
  logic [32:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [15:0] out_data0, out_data1, out_data2;
  logic [15:0] out_count0, out_count1, out_count2;
  logic        out_ovf0, out_ovf1, out_ovf2;

  int checks_q = 0;
  int errors_q = 0;

  always #5 clk = ~clk;

  // Default configuration.
  psum_accumulator u_dut0 (
    .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_count(out_count0),
    .out_overflow(out_ovf0)
  );

  // Scaled output: arithmetic shift by 2.
  psum_accumulator #(.OUT_SCALE(2)) u_dut1 (
    .clk(clk), .arst(arst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_count(out_count1),
    .out_overflow(out_ovf1)
  );

  // Narrow accumulator to exercise wrap detection.
  psum_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8)) u_dut2 (
    .clk(clk), .arst(arst), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_count(out_count2),
    .out_overflow(out_ovf2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [32:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst      = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    tick();

    check("rst_out_valid", out_valid0, 0);
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_data", out_data0, 0);
    check("rst_out_count", out_count0, 0);
    check("rst_out_ovf", out_ovf0, 0);

    // 5, -2, 10 -> 13
    send_beat(33'd5, 1'b0);
    check("mid_no_valid", out_valid0, 0);
    send_beat(-33'sd2, 1'b0);
    send_beat(33'd10, 1'b1);
    check("g1_valid", out_valid0, 1);
    check("g1_in_ready", in_ready0, 0);
    check("g1_data", out_data0, 16'd13);
    check("g1_count", out_count0, 3);
    check("g1_ovf", out_ovf0, 0);
    check("g1_scaled", out_data1, 16'd3);
    tick();
    check("g1_ret_valid", out_valid0, 0);
    check("g1_ret_ready", in_ready0, 1);
    check("g1_hold_data", out_data0, 16'd13);

    // -7, 0 -> scaled by 2 gives -2
    send_beat(-33'sd7, 1'b0);
    send_beat(33'd0, 1'b1);
    check("g2_scaled", out_data1, 16'hFFFE);
    check("g2_data", out_data0, 16'hFFF9);
    check("g2_count", out_count1, 2);
    tick();

    // Positive saturation
    send_beat(33'd30000, 1'b0);
    send_beat(33'd30000, 1'b1);
    check("g3_sat_max", out_data0, 16'h7FFF);
    check("g3_ovf", out_ovf0, 0);
    check("g3_scaled", out_data1, 16'h3A98);
    tick();

    // Negative saturation
    send_beat(-33'sd30000, 1'b0);
    send_beat(-33'sd30000, 1'b1);
    check("g4_sat_min", out_data0, 16'h8000);
    check("g4_ovf", out_ovf0, 0);
    check("g4_scaled", out_data1, 16'hC568);
    tick();

    // 8-bit accumulator wraps: 100 + 100 -> -56
    send_beat(33'd100, 1'b0);
    send_beat(33'd100, 1'b1);
    check("g5_wrap_ovf", out_ovf2, 1);
    check("g5_wrap_data", out_data2, 16'hFFC8);
    check("g5_wide_data", out_data0, 16'h00C8);
    check("g5_wide_ovf", out_ovf0, 0);
    tick();

    // Single beat after wrap: sticky flag cleared between groups
    send_beat(33'd1, 1'b1);
    check("g6_ovf_clr", out_ovf2, 0);
    check("g6_data", out_data2, 16'd1);
    check("g6_count", out_count2, 1);
    tick();

    // Backpressure
    out_ready = 1'b0;
    send_beat(33'd3, 1'b0);
    send_beat(33'd4, 1'b1);
    in_data  = 33'd100;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid0, 1);
      check("bp_data", out_data0, 16'd7);
      check("bp_count", out_count0, 2);
      check("bp_in_ready", in_ready0, 0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_valid", out_valid0, 0);
    check("bp_rel_ready", in_ready0, 1);
    tick();
    check("bp_one_xfer", out_valid0, 0);
    send_beat(33'd2, 1'b1);
    check("bp_next_data", out_data0, 16'd2);
    check("bp_next_count", out_count0, 1);
    tick();

    // Reset mid-group
    send_beat(33'd4, 1'b0);
    send_beat(33'd4, 1'b0);
    arst = 1'b1;
    #1;
    check("arst_async_valid", out_valid0, 0);
    check("arst_async_data", out_data0, 0);
    tick();
    arst = 1'b0;
    tick();
    check("arst_no_stale", out_valid0, 0);
    check("arst_in_ready", in_ready0, 1);
    send_beat(33'd1, 1'b1);
    check("arst_data", out_data0, 16'd1);
    check("arst_count", out_count0, 1);
    check("arst_valid", out_valid0, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule
`default_nettype wire
